// File: rtl/shift_reg_pkg.sv
// Shared types for the universal shift register: operation modes and FSM states.
package shift_reg_pkg;

  typedef enum logic [2:0] {
    MODE_HOLD  = 3'b000,
    MODE_LOAD  = 3'b001,
    MODE_SHL   = 3'b010,
    MODE_SHR   = 3'b011,
    MODE_ROTL  = 3'b100,
    MODE_ROTR  = 3'b101,
    MODE_ASR   = 3'b110,
    MODE_CLEAR = 3'b111
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/shift_reg_next.sv
// Combinational next-value mux for the universal shift register.
module shift_reg_next
  import shift_reg_pkg::*;
#(
  parameter int              WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  mode_e            mode_i,
  input  logic [WIDTH-1:0] q_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             sin_l_i,
  input  logic             sin_r_i,
  output logic [WIDTH-1:0] q_next_o
);

  always_comb begin
    q_next_o = q_i;
    unique case (mode_i)
      MODE_HOLD:  q_next_o = q_i;
      MODE_LOAD:  q_next_o = din_i;
      MODE_SHL:   q_next_o = {q_i[WIDTH-2:0], sin_r_i};
      MODE_SHR:   q_next_o = {sin_l_i, q_i[WIDTH-1:1]};
      MODE_ROTL:  q_next_o = {q_i[WIDTH-2:0], q_i[WIDTH-1]};
      MODE_ROTR:  q_next_o = {q_i[0], q_i[WIDTH-1:1]};
      MODE_ASR:   q_next_o = {q_i[WIDTH-1], q_i[WIDTH-1:1]};
      MODE_CLEAR: q_next_o = RST_VAL;
      default:    q_next_o = q_i;
    endcase
  end

endmodule

// File: rtl/shift_reg_univ.sv
// Universal WIDTH-bit shift register with a full-duplex LSB-first serial transfer sequencer.
// Optional parity outputs are enabled by defining SHIFT_REG_UNIV_PARITY_EN.
module shift_reg_univ
  import shift_reg_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             arst,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] din,
  input  logic             sin_l,
  input  logic             sin_r,
  input  logic             start,
  output logic [WIDTH-1:0] dout,
  output logic             sout,
  output logic             busy,
  output logic             done
`ifdef SHIFT_REG_UNIV_PARITY_EN
  ,
  output logic             parity,
  output logic             par_err
`endif
);

  localparam int CW = $clog2(WIDTH + 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] q_q, q_d;
  mode_e            nmode;

  // The sequencer reuses the mode mux: start forces LOAD, SHIFT forces SHR, DONE holds.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    nmode   = MODE_HOLD;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          nmode   = MODE_LOAD;
          cnt_d   = CW'(WIDTH);
          state_d = ST_SHIFT;
        end else begin
          nmode = mode_e'(mode);
        end
      end
      ST_SHIFT: begin
        nmode = MODE_SHR;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  shift_reg_next #(
    .WIDTH  (WIDTH),
    .RST_VAL(RST_VAL)
  ) u_next (
    .mode_i  (nmode),
    .q_i     (q_q),
    .din_i   (din),
    .sin_l_i (sin_l),
    .sin_r_i (sin_r),
    .q_next_o(q_d)
  );

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      q_q     <= RST_VAL;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
    end
  end

  assign dout = q_q;
  assign sout = q_q[0];
  assign busy = (state_q == ST_SHIFT);
  assign done = (state_q == ST_DONE);

`ifdef SHIFT_REG_UNIV_PARITY_EN
  logic par_err_q;

  // In DONE, sin_l carries the sender's parity bit for the word just received.
  always_ff @(posedge clk or posedge arst) begin
    if (arst)                                 par_err_q <= 1'b0;
    else if (state_q == ST_IDLE && start)     par_err_q <= 1'b0;
    else if (state_q == ST_DONE)              par_err_q <= (^q_q) ^ sin_l;
  end

  assign parity  = ^q_q;
  assign par_err = par_err_q;
`endif

endmodule

// File: doc/shift_reg_univ.md
Name: shift_reg_univ

Overview:
- Parametrised successor to the single-bit load-enable D flip-flop: a WIDTH-bit register with async reset and a universal operation set.
- Operations: hold, parallel load, shifts, rotates and synchronous clear.
- Built-in serial-transfer sequencer shifts the full word out LSB-first while capturing a serial word in (full-duplex).
- Used as the general register/serialiser primitive in datapaths and simple serial links.

Parameters:
- WIDTH, 8, register width in bits; must be >= 2.
- RST_VAL, {WIDTH{1'b0}}, value loaded by arst and by the CLEAR mode.

Ports:
- clk  in  1  clock, rising edge
- arst  in  1  asynchronous reset, active-high; forces all state to reset values
- mode  in  3  operation select, honoured only in IDLE
- din  in  WIDTH  parallel data in
- sin_l  in  1  serial in, enters MSB on right-shift and serial transfer
- sin_r  in  1  serial in, enters LSB on left-shift
- start  in  1  begin serial transfer, honoured only in IDLE
- dout  out  WIDTH  register contents q
- sout  out  1  serial out = q[0] (combinational from q)
- busy  out  1  high in SHIFT state
- done  out  1  one-cycle pulse after final transfer shift

Behaviour:
- Reset: arst (asynchronous, active-high; clock clk) sets q=RST_VAL, state=IDLE, cnt=0, busy=0, done=0. arst mid-transfer aborts immediately; no done pulse.
- All updates are on the rising edge of clk; results are visible on dout one cycle after the controlling inputs.
- Mode encoding (IDLE, start=0):
  - 000 HOLD
  - 001 LOAD: q<=din
  - 010 SHL: q<={q[W-2:0],sin_r}
  - 011 SHR: q<={sin_l,q[W-1:1]}
  - 100 ROTL
  - 101 ROTR
  - 110 ASR: MSB replicated
  - 111 CLEAR: q<=RST_VAL
- FSM states: IDLE, SHIFT, DONE.
- IDLE with start=1: q<=din, cnt<=WIDTH, go to SHIFT. start has priority over mode in the same cycle.
- SHIFT, each cycle: q<={sin_l,q[W-1:1]}, cnt<=cnt-1. When cnt==1, go to DONE. busy=1 throughout.
  - Exactly WIDTH shift cycles occur. sout presents din[0]..din[W-1] on successive SHIFT cycles.
  - After the transfer, q holds the WIDTH sin_l bits; the first received bit ends in q[0].
- DONE: done=1 for one cycle, q holds, then return to IDLE. mode and start are ignored in DONE.
- mode and start are ignored while busy. A start held high re-triggers only after returning to IDLE, giving a minimum one-cycle gap via DONE.
- cnt width is $clog2(WIDTH+1). No wrap occurs because the count terminates at 1.
- busy and done are registered (state decode), never combinational from inputs.

Optional Feature:
- Macro SHIFT_REG_UNIV_PARITY_EN.
- Defined:
  - Adds output port parity (1 bit) = ^q, even-parity bit of the current contents.
  - Adds output par_err (1 bit), registered. It is set in DONE if the received word's parity differs from sin_l sampled on the cycle after the last shift. It is cleared on the next start or by arst.
- Undefined: neither port exists and there is no parity logic.

Decomposition:
- Shared package shift_reg_pkg holds:
  - mode enum: MODE_HOLD..MODE_CLEAR, 3-bit
  - FSM state enum: ST_IDLE, ST_SHIFT, ST_DONE
- One sub-module is natural: shift_reg_next, the combinational next-value mux (mode, q, din, sin_l, sin_r -> q_next). The top module holds the register, FSM and counter.

Test Plan (WIDTH=8, RST_VAL=0):
1. Assert arst mid-SHIFT (cnt=5) -> dout=0x00, busy=0, done never pulses; next IDLE LOAD 0xA5 -> dout=0xA5 one cycle later.
2. LOAD 0x81, then SHL with sin_r=1 -> 0x03; ROTR -> 0x81; ASR -> 0xC0; CLEAR -> 0x00; HOLD for 3 cycles -> 0x00 stable.
3. start with din=0x5A, sin_l driven 1,0,1,1,0,0,1,0 on successive SHIFT cycles -> sout sequence 0,1,0,1,1,0,1,0; busy high for exactly 8 cycles; done pulses once; final dout=0x4D.
4. start and mode=LOAD asserted together in IDLE -> transfer begins (busy=1); din is loaded once; mode has no further effect.
5. Pulse start and toggle mode during SHIFT -> no restart and no q corruption; with start held high continuously, the next transfer begins one cycle after the done pulse.
6. (PARITY_EN) Transfer receiving 0x07 with trailing parity bit sin_l=0 -> par_err=1 in DONE; with trailing bit 1 -> par_err=0; parity output tracks ^dout every cycle.
